// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle for pipelined_barrel_shifter.
// The slave modport is the shifter side, the master modport is the producer/consumer side.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 25,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SHW-1:0]   out_shamt;
  logic             out_zero;
  logic             out_sticky;

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_shamt, out_zero, out_sticky
  );

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_shamt, out_zero, out_sticky
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Barrel shifter (SLL/SRL/SRA/NORM), one shift-amount bit per register stage, MSB bit first.
// Latency SHW cycles, 1 op/cycle; stalled stages hold, in_ready drops only when every stage is full.
// Define SHIFT_STICKY_EN to carry the OR of bits discarded by right shifts to out_sticky.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 25,
  parameter int SHW   = 5
) (
  input logic                       clk,
  input logic                       rst,
  pipelined_barrel_shifter_if.slave sh
);
  localparam logic [1:0] MODE_SRL  = 2'b01;
  localparam logic [1:0] MODE_SRA  = 2'b10;
  localparam logic [1:0] MODE_NORM = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    logic [1:0]       mode;
    logic             sticky;
  } stage_t;

  stage_t         st  [SHW];
  stage_t         nxt [SHW];
  stage_t         head;
  logic [SHW-1:0] vld;
  logic [SHW-1:0] src_vld;
  logic [SHW-1:0] load;
  logic [SHW-1:0] lzc;
  logic           zero_q;

  // NORM reuses the left-shift path with the leading-zero count; a zero operand keeps lzc=0.
  always_comb begin
    lzc = '0;
    for (int i = 0; i < WIDTH; i++)
      if (sh.in_data[i]) lzc = SHW'(WIDTH - 1 - i);
    head.data   = sh.in_data;
    head.shamt  = (sh.in_mode == MODE_NORM) ? lzc : sh.in_shamt;
    head.mode   = sh.in_mode;
    head.sticky = 1'b0;
  end

  always_comb begin
    stage_t cur;
    logic   cur_vld;
    cur     = head;
    cur_vld = sh.in_valid;
    for (int k = 0; k < SHW; k++) begin
      nxt[k]     = cur;
      src_vld[k] = cur_vld;
      if (cur.shamt[SHW-1-k]) begin
        case (cur.mode)
          MODE_SRL: nxt[k].data = cur.data >> (1 << (SHW - 1 - k));
          MODE_SRA: nxt[k].data = $unsigned($signed(cur.data) >>> (1 << (SHW - 1 - k)));
          default:  nxt[k].data = cur.data << (1 << (SHW - 1 - k));
        endcase
`ifdef SHIFT_STICKY_EN
        if (cur.mode == MODE_SRL || cur.mode == MODE_SRA)
          nxt[k].sticky = cur.sticky | (|(cur.data & ~({WIDTH{1'b1}} << (1 << (SHW - 1 - k)))));
`endif
      end
      cur     = st[k];
      cur_vld = vld[k];
    end
  end

  // A stage may load when empty or when its successor is loading this cycle.
  always_comb begin
    logic down;
    down = sh.out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      load[k] = !vld[k] || down;
      down    = load[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      zero_q <= 1'b0;
      for (int k = 0; k < SHW; k++) st[k] <= '0;
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (load[k]) begin
          vld[k] <= src_vld[k];
          if (src_vld[k]) st[k] <= nxt[k];
        end
      end
      if (load[SHW-1] && src_vld[SHW-1]) zero_q <= (nxt[SHW-1].data == '0);
    end
  end

  assign sh.in_ready  = !rst && load[0];
  assign sh.out_valid = vld[SHW-1];
  assign sh.out_data  = st[SHW-1].data;
  assign sh.out_shamt = st[SHW-1].shamt;
  assign sh.out_zero  = zero_q;
`ifdef SHIFT_STICKY_EN
  assign sh.out_sticky = st[SHW-1].sticky;
`else
  assign sh.out_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomised self-checking bench for pipelined_barrel_shifter against an arithmetic reference model.
module tb_pipelined_barrel_shifter;
  localparam int W = 25;
  localparam int S = 5;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, NORM = 2'b11;
`ifdef SHIFT_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] data;
    logic [S-1:0] shamt;
    logic         zero;
    logic         sticky;
    int           cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_out = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  res_t got_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_barrel_shifter_if #(.WIDTH(W), .SHW(S)) bus ();
  pipelined_barrel_shifter #(.WIDTH(W), .SHW(S)) dut (.clk(clk), .rst(rst), .sh(bus));

  // Output monitor: inputs change on negedge, so negedge+2 sees the values the next posedge will take.
  always begin
    @(negedge clk);
    #2;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got_q.push_back('{bus.out_data, bus.out_shamt, bus.out_zero, bus.out_sticky, cyc});
      n_out++;
    end
  end

  function automatic res_t model(input logic [W-1:0] d, input logic [S-1:0] sa, input logic [1:0] m);
    res_t   r;
    longint dv, p, v, q, full;
    int     n;
    full     = longint'(1) << W;
    dv       = longint'(d);
    p        = longint'(1) << sa;
    r.shamt  = sa;
    r.sticky = 1'b0;
    r.cyc    = 0;
    case (m)
      SLL: q = (dv * p) % full;
      SRL: begin
        q        = dv / p;
        r.sticky = ((dv % p) != 0);
      end
      SRA: begin
        v = d[W-1] ? dv - full : dv;
        q = (v >= 0) ? v / p : -((-v + p - 1) / p);
        if (q < 0) q = q + full;
        r.sticky = ((dv % p) != 0);
      end
      default: begin
        n = 0;
        if (dv != 0) while (d[W-1-n] == 1'b0) n++;
        q       = dv * (longint'(1) << n);
        r.shamt = S'(n);
      end
    endcase
    r.data = q[W-1:0];
    if (!STICKY_ON) r.sticky = 1'b0;
    r.zero = (r.data == '0);
    return r;
  endfunction

  task automatic offer(input logic [W-1:0] d, input logic [S-1:0] sa, input logic [1:0] m,
                       output bit ok, output int acc_cyc);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = sa;
    bus.in_mode  = m;
    ok      = 1'b0;
    acc_cyc = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      #1;
      if (bus.in_ready === 1'b1) begin
        ok      = 1'b1;
        acc_cyc = cyc;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shamt = '0; bus.in_mode = SLL;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    n_cmp++; if (bus.out_shamt !== '0) begin n_fail++; $display("FAIL reset_out_shamt: got %h expected 0", bus.out_shamt); end
    n_cmp++; if (bus.out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero: got %b expected 0", bus.out_zero); end
    n_cmp++; if (bus.out_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_out_sticky: got %b expected 0", bus.out_sticky); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_sll_latency();
    bit ok; int c; res_t r;
    got_q.delete();
    bus.out_ready = 1'b1;
    offer(25'h0000001, 5'd24, SLL, ok, c);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL sll_accept: in_ready never seen, expected accept"); end
    for (int t = 0; t < 20 && got_q.size() == 0; t++) begin @(negedge clk); #3; end
    n_cmp++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL sll_timeout: got no result, expected one within 20 cycles");
    end else begin
      r = got_q.pop_front();
      n_cmp++; if (r.data !== 25'h1000000) begin n_fail++; $display("FAIL sll_data: got %h expected 1000000", r.data); end
      n_cmp++; if (r.shamt !== 5'd24) begin n_fail++; $display("FAIL sll_shamt: got %0d expected 24", r.shamt); end
      n_cmp++; if (r.zero !== 1'b0) begin n_fail++; $display("FAIL sll_zero: got %b expected 0", r.zero); end
      n_cmp++; if (r.cyc - c != S) begin n_fail++; $display("FAIL sll_latency: got %0d edges expected %0d", r.cyc - c, S); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2; int c1, c2; res_t r1, r2;
    got_q.delete();
    bus.out_ready = 1'b1;
    offer(25'h1000000, 5'd4, SRA, ok1, c1);
    offer(25'h1000000, 5'd30, SRA, ok2, c2);
    n_cmp++; if (!(ok1 && ok2 && c2 == c1 + 1)) begin n_fail++; $display("FAIL b2b_accept: got ok=%b%b gap=%0d expected 11 gap=1", ok1, ok2, c2 - c1); end
    for (int t = 0; t < 20 && got_q.size() < 2; t++) begin @(negedge clk); #3; end
    n_cmp++;
    if (got_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d results expected 2", got_q.size());
    end else begin
      r1 = got_q.pop_front(); r2 = got_q.pop_front();
      n_cmp++; if (r1.data !== 25'h1F00000) begin n_fail++; $display("FAIL sra4_data: got %h expected 1f00000", r1.data); end
      n_cmp++; if (r2.data !== 25'h1FFFFFF) begin n_fail++; $display("FAIL sra30_data: got %h expected 1ffffff", r2.data); end
      n_cmp++; if (r2.shamt !== 5'd30) begin n_fail++; $display("FAIL sra30_shamt: got %0d expected 30", r2.shamt); end
      n_cmp++; if (r2.cyc != r1.cyc + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles expected 1", r2.cyc - r1.cyc); end
    end
    @(negedge clk);
  endtask

  task automatic test_norm();
    bit ok; int c; res_t r1, r2;
    got_q.delete();
    bus.out_ready = 1'b1;
    offer(25'h0000300, 5'd3, NORM, ok, c);
    offer(25'h0000000, 5'd7, NORM, ok, c);
    for (int t = 0; t < 20 && got_q.size() < 2; t++) begin @(negedge clk); #3; end
    n_cmp++;
    if (got_q.size() != 2) begin
      n_fail++; $display("FAIL norm_count: got %0d results expected 2", got_q.size());
    end else begin
      r1 = got_q.pop_front(); r2 = got_q.pop_front();
      n_cmp++; if (r1.data !== 25'h1800000) begin n_fail++; $display("FAIL norm_data: got %h expected 1800000", r1.data); end
      n_cmp++; if (r1.shamt !== 5'd15) begin n_fail++; $display("FAIL norm_shamt: got %0d expected 15", r1.shamt); end
      n_cmp++; if (r1.zero !== 1'b0) begin n_fail++; $display("FAIL norm_zero_flag: got %b expected 0", r1.zero); end
      n_cmp++; if (r2.data !== '0) begin n_fail++; $display("FAIL norm0_data: got %h expected 0", r2.data); end
      n_cmp++; if (r2.shamt !== '0) begin n_fail++; $display("FAIL norm0_shamt: got %0d expected 0", r2.shamt); end
      n_cmp++; if (r2.zero !== 1'b1) begin n_fail++; $display("FAIL norm0_zero: got %b expected 1", r2.zero); end
    end
    @(negedge clk);
  endtask

  task automatic test_sticky();
    bit ok; int c; res_t r1, r2;
    got_q.delete();
    bus.out_ready = 1'b1;
    offer(25'h0000013, 5'd2, SRL, ok, c);
    offer(25'h0000010, 5'd2, SRL, ok, c);
    for (int t = 0; t < 20 && got_q.size() < 2; t++) begin @(negedge clk); #3; end
    n_cmp++;
    if (got_q.size() != 2) begin
      n_fail++; $display("FAIL sticky_count: got %0d results expected 2", got_q.size());
    end else begin
      r1 = got_q.pop_front(); r2 = got_q.pop_front();
      n_cmp++; if (r1.data !== 25'h0000004) begin n_fail++; $display("FAIL srl2_data: got %h expected 0000004", r1.data); end
      n_cmp++; if (r1.sticky !== STICKY_ON) begin n_fail++; $display("FAIL srl2_sticky_set: got %b expected %b", r1.sticky, STICKY_ON); end
      n_cmp++; if (r2.data !== 25'h0000004) begin n_fail++; $display("FAIL srl2b_data: got %h expected 0000004", r2.data); end
      n_cmp++; if (r2.sticky !== 1'b0) begin n_fail++; $display("FAIL srl2_sticky_clear: got %b expected 0", r2.sticky); end
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    res_t exp_q[$]; res_t r, e;
    logic [W-1:0] d[8]; logic [S-1:0] sa[8]; logic [1:0] m[8];
    int sent = 0; int base = n_out; int occ; bit saw_full = 1'b0; bit exp_rdy;
    for (int i = 0; i < 8; i++) begin
      d[i]  = W'($urandom) >> $urandom_range(0, W - 1);
      sa[i] = S'($urandom_range(0, 31));
      m[i]  = 2'($urandom_range(0, 3));
    end
    got_q.delete();
    for (int t = 0; t < 200 && got_q.size() < 8; t++) begin
      bus.out_ready = !(t >= 3 && t < 9);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin bus.in_data = d[sent]; bus.in_shamt = sa[sent]; bus.in_mode = m[sent]; end
      #1;
      occ = sent - (n_out - base);
      exp_rdy = (occ < S) || bus.out_ready;
      n_cmp++; if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL stall_in_ready t=%0d: got %b expected %b", t, bus.in_ready, exp_rdy); end
      if (bus.in_ready === 1'b0 && !bus.out_ready) saw_full = 1'b1;
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        exp_q.push_back(model(d[sent], sa[sent], m[sent]));
        sent++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #3;
    n_cmp++; if (!saw_full) begin n_fail++; $display("FAIL stall_full: in_ready never fell, expected it to fall with %0d stages full", S); end
    n_cmp++; if (got_q.size() != 8) begin n_fail++; $display("FAIL stall_count: got %0d results expected 8", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      r = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (r.data !== e.data || r.shamt !== e.shamt || r.zero !== e.zero || r.sticky !== e.sticky) begin
        n_fail++; $display("FAIL stall_result: got %h/%0d/%b/%b expected %h/%0d/%b/%b", r.data, r.shamt, r.zero, r.sticky, e.data, e.shamt, e.zero, e.sticky);
      end
    end
  endtask

  task automatic test_random();
    res_t exp_q[$]; res_t r, e;
    logic [W-1:0] d; logic [S-1:0] sa; logic [1:0] m;
    int sent = 0;
    d = W'($urandom) >> $urandom_range(0, W - 1); sa = S'($urandom_range(0, 31)); m = 2'($urandom_range(0, 3));
    got_q.delete();
    for (int t = 0; t < 3000 && got_q.size() < 60; t++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.in_valid  = (sent < 60) && ($urandom_range(0, 9) < 7);
      bus.in_data = d; bus.in_shamt = sa; bus.in_mode = m;
      #1;
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        exp_q.push_back(model(d, sa, m));
        sent++;
        d = W'($urandom) >> $urandom_range(0, W - 1); sa = S'($urandom_range(0, 31)); m = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) @(negedge clk);
    #3;
    n_cmp++; if (got_q.size() != 60) begin n_fail++; $display("FAIL random_count: got %0d results expected 60", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      r = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (r.data !== e.data || r.shamt !== e.shamt || r.zero !== e.zero || r.sticky !== e.sticky) begin
        n_fail++; $display("FAIL random_result: got %h/%0d/%b/%b expected %h/%0d/%b/%b", r.data, r.shamt, r.zero, r.sticky, e.data, e.shamt, e.zero, e.sticky);
      end
    end
  endtask

  task automatic test_reset_flush();
    bit ok; int c; int base;
    bus.out_ready = 1'b1;
    offer(25'h0000001, 5'd1, SLL, ok, c);
    offer(25'h1234567, 5'd3, SRL, ok, c);
    offer(25'h0000300, 5'd0, NORM, ok, c);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL flush_out_data: got %h expected 0", bus.out_data); end
    base = n_out;
    repeat (12) @(negedge clk);
    #3;
    n_cmp++; if (n_out != base) begin n_fail++; $display("FAIL flush_stale: got %0d results expected 0", n_out - base); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sll_latency();
    test_back_to_back();
    test_norm();
    test_sticky();
    test_stall();
    test_random();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
